// File: rtl/bit_serializer_101_pkg.sv
// Shared definitions for the "101" serializer: FSM encoding and defaults
// that the downstream detector bench also uses.
package bit_serializer_101_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int   DEFAULT_WIDTH    = 8;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;

endpackage : bit_serializer_101_pkg

// File: rtl/bit_serializer_101_if.sv
// Parallel-in handshake and serial-out bundle of the "101" serializer.
interface bit_serializer_101_if #(
  parameter int WIDTH = bit_serializer_101_pkg::DEFAULT_WIDTH
);

  // Word transfer occurs at a rising edge where in_valid & in_ready are both
  // high; the source holds in_data/in_valid stable until that edge.
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             ser_bit;
  logic             ser_valid;
  logic             frame_start;
  logic             frame_end;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, ser_bit, ser_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, ser_bit, ser_valid, frame_start, frame_end, busy
  );

endinterface : bit_serializer_101_if

// File: rtl/bit_serializer_101.sv
// Parallel-to-serial feeder for the "101" detector: one bit per clock,
// gapless across back-to-back words, registered serial outputs.
module bit_serializer_101
  import bit_serializer_101_pkg::*;
#(
  parameter int   WIDTH     = DEFAULT_WIDTH,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = DEFAULT_IDLE_BIT
) (
  input  logic                    clk,
  input  logic                    rst,
  bit_serializer_101_if.slave     bus,
  output state_t                  dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ser_bit_q, ser_bit_d;
  logic             ser_valid_q, ser_valid_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_end_q, frame_end_d;

  logic last_bit;
  logic in_ready;
  logic handshake;

  assign last_bit  = (state_q == SHIFT) && (cnt_q == CNT_LAST);
  assign in_ready  = (state_q == IDLE) || last_bit;
  assign handshake = bus.in_valid && in_ready;

  // shreg_q always holds the bit on ser_bit at the outgoing end, so the
  // next bit to present is its neighbour one position inward.
  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    cnt_d         = cnt_q;
    ser_bit_d     = ser_bit_q;
    ser_valid_d   = ser_valid_q;
    frame_start_d = frame_start_q;
    frame_end_d   = frame_end_q;

    if (handshake) begin
      state_d       = SHIFT;
      shreg_d       = bus.in_data;
      cnt_d         = '0;
      ser_bit_d     = MSB_FIRST ? bus.in_data[WIDTH-1] : bus.in_data[0];
      ser_valid_d   = 1'b1;
      frame_start_d = 1'b1;
      frame_end_d   = 1'b0;
    end else if (state_q == SHIFT) begin
      if (last_bit) begin
        state_d       = IDLE;
        shreg_d       = '0;
        cnt_d         = '0;
        ser_bit_d     = IDLE_BIT;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
      end else begin
        shreg_d       = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
        cnt_d         = cnt_q + CW'(1);
        ser_bit_d     = MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1];
        ser_valid_d   = 1'b1;
        frame_start_d = 1'b0;
        frame_end_d   = (cnt_q == CNT_PENULT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      cnt_q         <= '0;
      ser_bit_q     <= IDLE_BIT;
      ser_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      cnt_q         <= cnt_d;
      ser_bit_q     <= ser_bit_d;
      ser_valid_q   <= ser_valid_d;
      frame_start_q <= frame_start_d;
      frame_end_q   <= frame_end_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.ser_bit     = ser_bit_q;
  assign bus.ser_valid   = ser_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
  assign bus.busy        = (state_q == SHIFT);
  assign dbg_state       = state_q;

endmodule : bit_serializer_101

// File: tb/tb_bit_serializer_101.sv
// Directed bench for bit_serializer_101: MSB-first and LSB-first instances
// sharing one clock and reset.
module tb_bit_serializer_101;
  import bit_serializer_101_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  bit_serializer_101_if #(.WIDTH(8)) bus_m ();
  bit_serializer_101_if #(.WIDTH(8)) bus_l ();
  state_t dbg_m, dbg_l;

  bit_serializer_101 #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_msb (
    .clk(clk), .rst(rst), .bus(bus_m), .dbg_state(dbg_m)
  );
  bit_serializer_101 #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bus(bus_l), .dbg_state(dbg_l)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Output tuple: {ser_bit, ser_valid, frame_start, frame_end, busy}
  function automatic logic [4:0] obs_m();
    return {bus_m.ser_bit, bus_m.ser_valid, bus_m.frame_start, bus_m.frame_end, bus_m.busy};
  endfunction
  function automatic logic [4:0] obs_l();
    return {bus_l.ser_bit, bus_l.ser_valid, bus_l.frame_start, bus_l.frame_end, bus_l.busy};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus_m.in_valid = 1'b0; bus_m.in_data = '0;
    bus_l.in_valid = 1'b0; bus_l.in_data = '0;
    rst = 1'b0;
    @(negedge clk);
    tests_run++;
    if (obs_m() !== 5'b00000 || dbg_m !== IDLE) begin
      tests_failed++;
      $display("FAIL reset_outputs got %b/%0d exp 00000/0", obs_m(), dbg_m);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_m.in_ready !== 1'b1 || bus_l.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready got %b%b exp 11", bus_m.in_ready, bus_l.in_ready);
    end
  endtask

  task automatic test_single_msb();
    logic [7:0] word = 8'b1010_0000;
    logic [4:0] exp;
    bus_m.in_data = word; bus_m.in_valid = 1'b1;
    tests_run++;
    if (bus_m.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_ready got %b exp 1", bus_m.in_ready);
    end
    @(negedge clk);
    bus_m.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {word[7-k], 1'b1, k == 0, k == 7, 1'b1};
      tests_run++;
      if (obs_m() !== exp) begin
        tests_failed++;
        $display("FAIL single_bit k=%0d got %b exp %b", k, obs_m(), exp);
      end
      @(negedge clk);
    end
    tests_run++;
    if (obs_m() !== 5'b00000 || bus_m.in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_idle got %b rdy %b exp 00000 rdy 1", obs_m(), bus_m.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream = 16'hA55A;
    logic [4:0]  exp;
    bus_m.in_data = 8'hA5; bus_m.in_valid = 1'b1;
    @(negedge clk);
    bus_m.in_data = 8'h5A;
    for (int k = 0; k < 16; k++) begin
      if (k == 8) begin
        bus_m.in_valid = 1'b0;
        bus_m.in_data  = 8'h00;
      end
      exp = {stream[15-k], 1'b1, (k == 0) || (k == 8), (k == 7) || (k == 15), 1'b1};
      tests_run++;
      if (obs_m() !== exp || bus_m.in_ready !== ((k == 7) || (k == 15))) begin
        tests_failed++;
        $display("FAIL b2b_bit k=%0d got %b rdy %b exp %b rdy %b", k, obs_m(),
                 bus_m.in_ready, exp, (k == 7) || (k == 15));
      end
      @(negedge clk);
    end
    tests_run++;
    if (obs_m() !== 5'b00000) begin
      tests_failed++;
      $display("FAIL b2b_idle got %b exp 00000", obs_m());
    end
  endtask

  task automatic test_lsb_first();
    logic [7:0] exp_bits = 8'b1010_0000;
    logic [4:0] exp;
    bus_l.in_data = 8'h05; bus_l.in_valid = 1'b1;
    @(negedge clk);
    bus_l.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {exp_bits[7-k], 1'b1, k == 0, k == 7, 1'b1};
      tests_run++;
      if (obs_l() !== exp) begin
        tests_failed++;
        $display("FAIL lsb_bit k=%0d got %b exp %b", k, obs_l(), exp);
      end
      @(negedge clk);
    end
    tests_run++;
    if (obs_l() !== 5'b00000 || dbg_l !== IDLE) begin
      tests_failed++;
      $display("FAIL lsb_idle got %b exp 00000", obs_l());
    end
  endtask

  task automatic test_hold_off();
    logic [15:0] stream = 16'hA5FF;
    logic [4:0]  exp;
    bus_m.in_data = 8'hA5; bus_m.in_valid = 1'b1;
    @(negedge clk);
    bus_m.in_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (k == 2) begin
        bus_m.in_data  = 8'hFF;
        bus_m.in_valid = 1'b1;
      end
      if (k == 8) bus_m.in_valid = 1'b0;
      exp = {stream[15-k], 1'b1, (k == 0) || (k == 8), (k == 7) || (k == 15), 1'b1};
      tests_run++;
      if (obs_m() !== exp || bus_m.in_ready !== ((k == 7) || (k == 15))) begin
        tests_failed++;
        $display("FAIL hold_bit k=%0d got %b rdy %b exp %b rdy %b", k, obs_m(),
                 bus_m.in_ready, exp, (k == 7) || (k == 15));
      end
      @(negedge clk);
    end
    tests_run++;
    if (obs_m() !== 5'b00000) begin
      tests_failed++;
      $display("FAIL hold_idle got %b exp 00000", obs_m());
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] first = 8'hA5;
    logic [7:0] second = 8'h80;
    logic [4:0] exp;
    bus_m.in_data = first; bus_m.in_valid = 1'b1;
    @(negedge clk);
    bus_m.in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp = {first[7-k], 1'b1, k == 0, 1'b0, 1'b1};
      tests_run++;
      if (obs_m() !== exp) begin
        tests_failed++;
        $display("FAIL midrst_bit k=%0d got %b exp %b", k, obs_m(), exp);
      end
      @(negedge clk);
    end
    #1 rst = 1'b0;
    #1;
    tests_run++;
    if (obs_m() !== 5'b00000 || dbg_m !== IDLE) begin
      tests_failed++;
      $display("FAIL midrst_async got %b exp 00000", obs_m());
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_m.in_ready !== 1'b1 || obs_m() !== 5'b00000) begin
      tests_failed++;
      $display("FAIL midrst_release got %b rdy %b exp 00000 rdy 1", obs_m(), bus_m.in_ready);
    end
    bus_m.in_data = second; bus_m.in_valid = 1'b1;
    @(negedge clk);
    bus_m.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp = {second[7-k], 1'b1, k == 0, k == 7, 1'b1};
      tests_run++;
      if (obs_m() !== exp) begin
        tests_failed++;
        $display("FAIL midrst_new k=%0d got %b exp %b", k, obs_m(), exp);
      end
      @(negedge clk);
    end
  endtask

  // Small reference "101" detector applied to the observed serial stream.
  task automatic test_integration();
    logic [2:0] hist = 3'b000;
    logic [7:0] det  = 8'h00;
    int         nvalid = 0;
    bus_m.in_data = 8'b1010_1000; bus_m.in_valid = 1'b1;
    @(negedge clk);
    bus_m.in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus_m.ser_valid === 1'b1) begin
        hist = {hist[1:0], bus_m.ser_bit};
        if (hist == 3'b101 && nvalid >= 2) det[nvalid] = 1'b1;
        nvalid++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (det !== 8'b0001_0100 || nvalid != 8) begin
      tests_failed++;
      $display("FAIL integ_detect got %b n=%0d exp 00010100 n=8", det, nvalid);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_single_msb();
    test_back_to_back();
    test_lsb_first();
    test_hold_off();
    test_reset_mid_frame();
    test_integration();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_bit_serializer_101

// File: doc/bit_serializer_101.md
Name: bit_serializer_101

Overview:
- Upstream feeder for the serial "101" sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock.
- Output is a serial stream (ser_bit) with a qualifying valid, driven straight into the detector's serial input I.
- Back-to-back words produce a gapless bit stream, so sequences spanning word boundaries are still presented contiguously.

Parameters:
- WIDTH, 8: bits per parallel word; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 shifted out first; 0 = bit 0 first.
- IDLE_BIT, 0: value driven on ser_bit whenever ser_valid is low.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_data  in  WIDTH  parallel word to serialize.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle (combinational).
- ser_bit  out  1  serial output bit (registered); feeds detector input I.
- ser_valid  out  1  ser_bit carries a data bit this cycle (registered).
- frame_start  out  1  high while the first bit of a word is on ser_bit.
- frame_end  out  1  high while the last bit of a word is on ser_bit.
- busy  out  1  high in SHIFT state.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, shift register=0, bit counter=0.
  - ser_bit=IDLE_BIT; ser_valid, frame_start, frame_end, busy all 0.
  - in_ready=1 once rst is released.
- States: IDLE, SHIFT.
- in_ready = (state==IDLE) | (state==SHIFT & cnt==WIDTH-1). Handshake = in_valid & in_ready at a rising edge.
- IDLE:
  - On handshake, load in_data, go to SHIFT, cnt=0.
  - The first bit appears on ser_bit in the cycle after the handshake edge (latency 1), with ser_valid=1 and frame_start=1.
- SHIFT:
  - Each edge advances cnt and presents the next bit; each bit is held exactly one cycle.
  - cnt counts 0..WIDTH-1; width is $clog2(WIDTH).
- Last bit (cnt==WIDTH-1):
  - frame_end=1.
  - Handshake this cycle: load the new word, cnt wraps to 0, stay in SHIFT; the new word's first bit follows with zero gap.
  - No handshake: return to IDLE; ser_valid=0 and ser_bit=IDLE_BIT next cycle.
- Bit order:
  - MSB_FIRST=1: in_data[WIDTH-1] first, down to in_data[0].
  - MSB_FIRST=0: in_data[0] first, up to in_data[WIDTH-1].
- in_data is sampled only on the handshake edge; changes at any other time have no effect.
- in_valid while in_ready=0 is ignored; the source holds the word until accepted.
- A frame is never truncated or restarted except by reset.
- Reset mid-frame: the remaining bits are discarded and outputs go to reset values immediately (asynchronous).
- frame_start and frame_end are never both high, since WIDTH>=2.
- busy=1 exactly when state==SHIFT.

Decomposition:
- Shared package holds:
  - state enum {IDLE, SHIFT} (1-bit encoding);
  - the default WIDTH constant;
  - the IDLE_BIT default, shared with the detector bench.
- No sub-module: the shift register, counter and two-state FSM live in one module.
- Top-level integration (bit_serializer_101 driving the detector) is a separate wrapper; it is not part of this block.

Test Plan:
- Reset, then WIDTH=8, MSB_FIRST=1: load 8'b1010_0000 -> ser_bit = 1,0,1,0,0,0,0,0 on 8 consecutive cycles starting 1 cycle after handshake. ser_valid high for exactly 8 cycles, frame_start on cycle 1, frame_end on cycle 8, then ser_bit=0 and ser_valid=0.
- Back-to-back: in_valid held with 8'hA5 then 8'h5A -> in_ready high only in IDLE and on each last-bit cycle. 16 contiguous valid bits 1010_0101_0101_1010 with no gap; frame_end on bits 8 and 16.
- MSB_FIRST=0: load 8'h05 -> ser_bit = 1,0,1,0,0,0,0,0.
- Hold-off: assert in_valid with 8'hFF during bit 3 of a frame -> in_ready stays 0 until bit 8. 8'hFF is accepted on the bit-8 edge, and its first bit immediately follows bit 8 of the current frame.
- Reset mid-frame: drop rst low after bit 3 of 8'hA5 -> ser_valid=0 and busy=0 immediately. After release, in_ready=1, and a new word 8'h80 serializes from its first bit.
- Integration: feed 8'b1010_1000 into the detector -> detector F asserts after the 3rd and 5th serial bits, i.e. on the overlapping 101s.
